// File: rtl/wb_split_pkg.sv
// Shared types for the user-window splitter: FSM states, target kinds, status layout, error word.
// Pure declarations; no timing or flow-control behaviour of its own.
package wb_split_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLV,
        ST_DBG,
        ST_UNM,
        ST_RESP
    } state_t;

    localparam logic [1:0] TGT_SLV = 2'd0;
    localparam logic [1:0] TGT_DBG = 2'd1;
    localparam logic [1:0] TGT_UNM = 2'd2;

    localparam int STAT_TOCNT_LSB  = 0;
    localparam int STAT_LASTTO_LSB = 16;
    localparam int STAT_NSLV_LSB   = 19;

    localparam logic [31:0] DEF_ERR_WORD = 32'hDEAD_BEEF;

    function automatic logic [31:0] status_word(input logic [15:0] to_cnt,
                                                input logic [2:0]  last_to,
                                                input logic [4:0]  nslv);
        logic [31:0] w;
        w = '0;
        w[STAT_TOCNT_LSB  +: 16] = to_cnt;
        w[STAT_LASTTO_LSB +: 3]  = last_to;
        w[STAT_NSLV_LSB   +: 5]  = nslv;
        return w;
    endfunction

endpackage

// File: rtl/wb_user_splitter_if.sv
// Upstream Wishbone port plus the broadcast/per-slave fabric of the splitter.
// slave modport is the splitter's view; master modport is the surrounding environment.
interface wb_user_splitter_if #(parameter int NUM_SLV = 2);

    logic                    wbs_cyc_i;
    logic                    wbs_stb_i;
    logic                    wbs_we_i;
    logic [3:0]              wbs_sel_i;
    logic [31:0]             wbs_adr_i;
    logic [31:0]             wbs_dat_i;
    logic                    wbs_ack_o;
    logic [31:0]             wbs_dat_o;

    logic [NUM_SLV-1:0]      s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [3:0]              s_sel_o;
    logic [31:0]             s_adr_o;
    logic [31:0]             s_dat_o;
    logic [NUM_SLV-1:0]      s_ack_i;
    logic [NUM_SLV*32-1:0]   s_dat_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i
    );

endinterface

// File: rtl/wb_dbg_regbank.sv
// Byte-writable debug words plus read-only status word (timeout count / last target), clear on status write.
// Writes land on the clock edge of wr_i; read mux is combinational; no backpressure.
module wb_dbg_regbank
    import wb_split_pkg::*;
#(
    parameter int DBG_REGS = 2,
    parameter int NUM_SLV  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_i,
    input  logic [3:0]             idx_i,
    input  logic [3:0]             sel_i,
    input  logic [31:0]            wdat_i,
    output logic [31:0]            rdat_o,
    input  logic                   to_fire_i,
    input  logic [2:0]             to_tgt_i,
    output logic [DBG_REGS*32-1:0] dbg_o
);

    logic [DBG_REGS-1:0][31:0] regs_q;
    logic [15:0]               to_cnt_q;
    logic [2:0]                last_to_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q    <= '0;
            to_cnt_q  <= '0;
            last_to_q <= '0;
        end else begin
            for (int k = 0; k < DBG_REGS; k++) begin
                if (wr_i && idx_i == 4'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel_i[b]) regs_q[k][8*b +: 8] <= wdat_i[8*b +: 8];
                    end
                end
            end
            // Index DBG_REGS is the status word: any write clears the timeout record.
            if (wr_i && idx_i == 4'(DBG_REGS)) begin
                to_cnt_q  <= '0;
                last_to_q <= '0;
            end else if (to_fire_i) begin
                if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
                last_to_q <= to_tgt_i;
            end
        end
    end

    always_comb begin
        rdat_o = status_word(to_cnt_q, last_to_q, 5'(NUM_SLV));
        for (int k = 0; k < DBG_REGS; k++) begin
            if (idx_i == 4'(k)) rdat_o = regs_q[k];
        end
    end

    assign dbg_o = regs_q;

endmodule

// File: rtl/wb_user_splitter.sv
// Splits the user window into NUM_SLV slave regions plus a debug bank; one transaction in flight.
// Ack latency: slave ack + 1, debug/unmapped 2 cycles; timeout returns ERR_WORD; master cyc drop aborts.
module wb_user_splitter
    import wb_split_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h3000_0000,
    parameter int          WIN_AW   = 20,
    parameter int          NUM_SLV  = 2,
    parameter int          DBG_REGS = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = DEF_ERR_WORD
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_user_splitter_if.slave      bus,
    output logic [DBG_REGS*32-1:0] dbg_o,
    output logic                   timeout_o
);

    localparam longint          REG_BYTES = (longint'(1) << WIN_AW) / NUM_SLV;
    localparam logic [WIN_AW-3:0] DBG_LO_W =
        (WIN_AW-2)'((longint'(1) << (WIN_AW-2)) - 1 - DBG_REGS);

    state_t              state_q;
    logic [NUM_SLV-1:0]  s_cyc_q;
    logic                s_stb_q, s_we_q;
    logic [3:0]          s_sel_q;
    logic [31:0]         s_adr_q, s_dat_q;
    logic                ack_q, timeout_q;
    logic [31:0]         dat_q;
    logic [15:0]         to_q;
    logic [2:0]          sidx_q;
    logic [3:0]          didx_q;

    logic [WIN_AW-1:0]   off;
    logic [WIN_AW-3:0]   widx;
    logic [1:0]          dec_kind;
    logic [2:0]          dec_sidx;
    logic [3:0]          dec_didx;
    logic [NUM_SLV-1:0]  dec_oh;
    logic                slv_ack;
    logic [31:0]         slv_dat;
    logic                to_fire;
    logic                dbg_wr;
    logic [31:0]         bank_rdat;

    assign off  = bus.wbs_adr_i[WIN_AW-1:0];
    assign widx = off[WIN_AW-1:2];

    // The debug block sits at the top of the window and overrides the last slave region.
    always_comb begin
        dec_kind = TGT_UNM;
        dec_sidx = '0;
        dec_didx = '0;
        dec_oh   = '0;
        if (bus.wbs_adr_i[31:WIN_AW] == BASE[31:WIN_AW]) begin
            if (widx >= DBG_LO_W) begin
                dec_kind = TGT_DBG;
                dec_didx = 4'(widx - DBG_LO_W);
            end else begin
                dec_kind = TGT_SLV;
                for (int i = 1; i < NUM_SLV; i++) begin
                    if (off >= WIN_AW'(longint'(i) * REG_BYTES)) dec_sidx = 3'(i);
                end
            end
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            dec_oh[i] = (dec_kind == TGT_SLV) && (dec_sidx == 3'(i));
        end
    end

    // s_cyc_q is one-hot on the selected slave, so it doubles as the ack/data select.
    always_comb begin
        slv_ack = |(bus.s_ack_i & s_cyc_q);
        slv_dat = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s_cyc_q[i]) slv_dat = bus.s_dat_i[32*i +: 32];
        end
    end

    assign to_fire = (state_q == ST_SLV) && bus.wbs_cyc_i && !slv_ack && (to_q == 16'(TIMEOUT));
    assign dbg_wr  = (state_q == ST_DBG) && bus.wbs_cyc_i && s_we_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            s_cyc_q   <= '0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_sel_q   <= '0;
            s_adr_q   <= '0;
            s_dat_q   <= '0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            dat_q     <= '0;
            to_q      <= '0;
            sidx_q    <= '0;
            didx_q    <= '0;
        end else begin
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        s_we_q  <= bus.wbs_we_i;
                        s_sel_q <= bus.wbs_sel_i;
                        s_adr_q <= bus.wbs_adr_i;
                        s_dat_q <= bus.wbs_dat_i;
                        sidx_q  <= dec_sidx;
                        didx_q  <= dec_didx;
                        to_q    <= '0;
                        case (dec_kind)
                            TGT_SLV: begin
                                state_q <= ST_SLV;
                                s_cyc_q <= dec_oh;
                                s_stb_q <= 1'b1;
                            end
                            TGT_DBG: state_q <= ST_DBG;
                            default: state_q <= ST_UNM;
                        endcase
                    end
                end
                ST_SLV: begin
                    if (!bus.wbs_cyc_i) begin
                        state_q <= ST_IDLE;
                        s_cyc_q <= '0;
                        s_stb_q <= 1'b0;
                    end else if (slv_ack) begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        dat_q   <= slv_dat;
                        s_cyc_q <= '0;
                        s_stb_q <= 1'b0;
                    end else if (to_fire) begin
                        state_q   <= ST_RESP;
                        ack_q     <= 1'b1;
                        dat_q     <= ERR_WORD;
                        timeout_q <= 1'b1;
                        s_cyc_q   <= '0;
                        s_stb_q   <= 1'b0;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                ST_DBG: begin
                    if (!bus.wbs_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        dat_q   <= bank_rdat;
                    end
                end
                ST_UNM: begin
                    if (!bus.wbs_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                        ack_q   <= 1'b1;
                        dat_q   <= ERR_WORD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wb_dbg_regbank #(
        .DBG_REGS (DBG_REGS),
        .NUM_SLV  (NUM_SLV)
    ) u_regbank (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .wr_i      (dbg_wr),
        .idx_i     (didx_q),
        .sel_i     (s_sel_q),
        .wdat_i    (s_dat_q),
        .rdat_o    (bank_rdat),
        .to_fire_i (to_fire),
        .to_tgt_i  (sidx_q),
        .dbg_o     (dbg_o)
    );

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign bus.s_cyc_o   = s_cyc_q;
    assign bus.s_stb_o   = s_stb_q;
    assign bus.s_we_o    = s_we_q;
    assign bus.s_sel_o   = s_sel_q;
    assign bus.s_adr_o   = s_adr_q;
    assign bus.s_dat_o   = s_dat_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_wb_user_splitter.sv
// Directed bench for wb_user_splitter (NUM_SLV=2, DBG_REGS=2, TIMEOUT=8) with a read-data scoreboard.
module tb_wb_user_splitter;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] STATUS_A = BASE + 32'h000F_FFFC;
    localparam logic [31:0] DBG0_A   = BASE + 32'h000F_FFF4;
    localparam logic [31:0] DBG1_A   = BASE + 32'h000F_FFF8;
    localparam logic [31:0] SLV1_A   = BASE + 32'h0008_0000;
    localparam logic [31:0] ERR      = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] dbg;
    logic        tmo;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    int          lat;
    logic [31:0] dat;
    logic [1:0]  cyc_seen;
    logic        to_seen;
    logic        ack_next;

    wb_user_splitter_if #(.NUM_SLV(2)) bus();

    wb_user_splitter #(
        .BASE     (BASE),
        .WIN_AW   (20),
        .NUM_SLV  (2),
        .DBG_REGS (2),
        .TIMEOUT  (8),
        .ERR_WORD (ERR)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus.slave),
        .dbg_o     (dbg),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check(tag, {32'h0, obs}, {32'h0, exp});
    endtask

    // One request; optionally raises s_ack_i[ack_slv] after negedge ack_at with data rdv.
    // lat counts clock edges from the request until wbs_ack_o is seen (0 = never within budget).
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input int ack_slv, input int ack_at,
                        input logic [31:0] rdv, output int lat_o, output logic [31:0] dat_o,
                        output logic [1:0] cyc_o, output logic to_o, output logic ack_nx);
        lat_o = 0; dat_o = '0; cyc_o = '0; to_o = 1'b0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            cyc_o = cyc_o | bus.s_cyc_o;
            to_o  = to_o | tmo;
            bus.s_ack_i = '0;
            if (bus.wbs_ack_o) begin
                lat_o = n;
                dat_o = bus.wbs_dat_o;
                break;
            end
            if (n == ack_at && ack_slv >= 0) begin
                bus.s_ack_i[ack_slv] = 1'b1;
                bus.s_dat_i[32*ack_slv +: 32] = rdv;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.s_ack_i = '0;
        @(negedge clk);
        ack_nx = bus.wbs_ack_o;
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
        bus.s_ack_i   = '0;   bus.s_dat_i   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack",  {63'h0, bus.wbs_ack_o}, 64'h0);
        check("rst_dat",  {32'h0, bus.wbs_dat_o}, 64'h0);
        check("rst_scyc", {62'h0, bus.s_cyc_o},   64'h0);
        check("rst_sstb", {63'h0, bus.s_stb_o},   64'h0);
        check("rst_dbg",  dbg,                    64'h0);
        check("rst_to",   {63'h0, tmo},           64'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: write to slave1, ack raised 3 cycles after s_cyc_o
        exp_q.push_back(32'hCAFE_0001);
        xfer(1'b1, SLV1_A, 32'h1234_5678, 4'hF, 1, 3, 32'hCAFE_0001, lat, dat, cyc_seen, to_seen, ack_next);
        check("t1_lat",   lat,               64'd4);
        sb_check("t1_dat", dat);
        check("t1_cyc",   {62'h0, cyc_seen}, 64'h2);
        check("t1_to",    {63'h0, to_seen},  64'h0);
        check("t1_ack1c", {63'h0, ack_next}, 64'h0);
        check("t1_sdat",  {32'h0, bus.s_dat_o}, {32'h0, 32'h1234_5678});
        check("t1_sadr",  {32'h0, bus.s_adr_o}, {32'h0, SLV1_A});

        // 2: byte-masked debug write, full write to reg1, readback
        xfer(1'b1, DBG0_A, 32'hA5A5_A5A5, 4'b0011, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        check("t2_wlat",  lat,              64'd2);
        check("t2_dbg0",  {32'h0, dbg[31:0]}, {32'h0, 32'h0000_A5A5});
        xfer(1'b1, DBG1_A, 32'h1122_3344, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        check("t2_dbg1",  {32'h0, dbg[63:32]}, {32'h0, 32'h1122_3344});
        exp_q.push_back(32'h0000_A5A5);
        xfer(1'b0, DBG0_A, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        check("t2_rlat",  lat,               64'd2);
        sb_check("t2_rdat", dat);
        check("t2_cyc",   {62'h0, cyc_seen}, 64'h0);

        // 3: slave0 never acks -> timeout after 9 cycles of s_cyc_o
        exp_q.push_back(ERR);
        xfer(1'b0, BASE + 32'h100, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        check("t3_lat",   lat,               64'd10);
        sb_check("t3_dat", dat);
        check("t3_to",    {63'h0, to_seen},  64'h1);
        check("t3_cyc",   {62'h0, cyc_seen}, 64'h1);
        exp_q.push_back(32'h0010_0001);
        xfer(1'b0, STATUS_A, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        sb_check("t3_status", dat);
        // Ack arriving on the expiry cycle wins
        exp_q.push_back(32'h5A5A_0000);
        xfer(1'b0, BASE + 32'h200, '0, 4'hF, 0, 9, 32'h5A5A_0000, lat, dat, cyc_seen, to_seen, ack_next);
        check("t3b_lat",  lat,              64'd10);
        sb_check("t3b_dat", dat);
        check("t3b_to",   {63'h0, to_seen}, 64'h0);
        exp_q.push_back(32'h0010_0001);
        xfer(1'b0, STATUS_A, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        sb_check("t3b_status", dat);
        xfer(1'b1, STATUS_A, 32'h1234_0000, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        exp_q.push_back(32'h0010_0000);
        xfer(1'b0, STATUS_A, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        sb_check("t3c_status_clr", dat);

        // 4: unmapped read
        exp_q.push_back(ERR);
        xfer(1'b0, 32'h2000_0000, '0, 4'hF, -1, 0, '0, lat, dat, cyc_seen, to_seen, ack_next);
        check("t4_lat",   lat,               64'd2);
        sb_check("t4_dat", dat);
        check("t4_cyc",   {62'h0, cyc_seen}, 64'h0);

        // 5: master drops cyc two cycles into a slave access; late acks ignored
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = BASE + 32'h40;
        @(negedge clk);
        check("t5_cyc_up", {62'h0, bus.s_cyc_o}, 64'h1);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("t5_cyc_dn", {62'h0, bus.s_cyc_o}, 64'h0);
        check("t5_noack",  {63'h0, bus.wbs_ack_o}, 64'h0);
        bus.s_ack_i = 2'b11;
        @(negedge clk);
        bus.s_ack_i = '0;
        check("t5_stray",  {63'h0, bus.wbs_ack_o}, 64'h0);
        @(negedge clk);
        check("t5_stray2", {63'h0, bus.wbs_ack_o}, 64'h0);
        // Abort during DBG: no write, no ack
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = DBG0_A; bus.wbs_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("t5_dbg_noack", {63'h0, bus.wbs_ack_o}, 64'h0);
        @(negedge clk);
        check("t5_dbg_nowr", {32'h0, dbg[31:0]}, {32'h0, 32'h0000_A5A5});

        // 6: reset mid slave access
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = SLV1_A; bus.wbs_dat_i = 32'h7777_8888;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("t6_ack",  {63'h0, bus.wbs_ack_o}, 64'h0);
        check("t6_dat",  {32'h0, bus.wbs_dat_o}, 64'h0);
        check("t6_scyc", {62'h0, bus.s_cyc_o},   64'h0);
        check("t6_sstb", {63'h0, bus.s_stb_o},   64'h0);
        check("t6_swe",  {63'h0, bus.s_we_o},    64'h0);
        check("t6_sadr", {32'h0, bus.s_adr_o},   64'h0);
        check("t6_sdat", {32'h0, bus.s_dat_o},   64'h0);
        check("t6_ssel", {60'h0, bus.s_sel_o},   64'h0);
        check("t6_dbg",  dbg,                    64'h0);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(32'h0BAD_F00D);
        xfer(1'b0, BASE + 32'h10, '0, 4'hF, 0, 2, 32'h0BAD_F00D, lat, dat, cyc_seen, to_seen, ack_next);
        check("t6_lat",  lat,               64'd3);
        sb_check("t6_post", dat);
        check("t6_cyc",  {62'h0, cyc_seen}, 64'h1);
        check("t6_sbq",  exp_q.size(),      64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
